// File: rtl/mult_seq.sv
// Sequential shift-add multiplier (MULT/MULTU): WIDTH CALC steps on operand
// magnitudes, then a FIX step that applies the result sign and publishes {hi,lo}.
module mult_seq #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cancel,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t               r_state;
   logic [CW-1:0]        r_cnt;
   logic [WIDTH-1:0]     r_mcand;
   logic [2*WIDTH-1:0]   r_acc;
   logic                 r_neg;
   logic                 r_busy;
   logic                 r_done;
   logic [WIDTH-1:0]     r_hi;
   logic [WIDTH-1:0]     r_lo;

   logic [WIDTH-1:0]     w_mag_a;
   logic [WIDTH-1:0]     w_mag_b;
   logic [WIDTH:0]       w_sum;
   logic [2*WIDTH-1:0]   w_res;

   // Magnitude of the most negative value wraps to 2^(WIDTH-1), which is exact unsigned
   assign w_mag_a = (is_signed && a[WIDTH-1]) ? WIDTH'(-a) : a;
   assign w_mag_b = (is_signed && b[WIDTH-1]) ? WIDTH'(-b) : b;

   assign w_sum = r_acc[0] ? ({1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand})
                           :  {1'b0, r_acc[2*WIDTH-1:WIDTH]};
   assign w_res = r_neg ? (2*WIDTH)'(-r_acc) : r_acc;

   assign busy = r_busy;
   assign done = r_done;
   assign hi   = r_hi;
   assign lo   = r_lo;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_mcand <= '0;
         r_acc   <= '0;
         r_neg   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_hi    <= '0;
         r_lo    <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start && !cancel) begin
                  r_mcand <= w_mag_a;
                  r_acc   <= {WIDTH'(0), w_mag_b};
                  r_neg   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                  r_cnt   <= CW'(WIDTH);
                  r_busy  <= 1'b1;
                  r_state <= S_CALC;
               end
            end
            S_CALC: begin
               if (cancel) begin
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  // Carry out of the add lands in the top bit as the register shifts right
                  r_acc <= {w_sum, r_acc[WIDTH-1:1]};
                  r_cnt <= r_cnt - CW'(1);
                  if (r_cnt == CW'(1)) begin
                     r_state <= S_FIX;
                  end
               end
            end
            S_FIX: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
               if (!cancel) begin
                  {r_hi, r_lo} <= w_res;
                  r_done       <= 1'b1;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult_seq.sv
// Directed bench for mult_seq at WIDTH=32: latency, signed corners, back-to-back,
// cancel, async reset, plus a short run of corner-biased random operands.
module tb_mult_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        is_signed;
   logic [31:0] a;
   logic [31:0] b;
   logic        cancel;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_cmp = 0;
   int n_err = 0;

   mult_seq #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
      .a(a), .b(b), .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one op at a negedge, then return at the negedge where done is seen
   task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic s,
                         output int edges, output int busy_cyc);
      @(negedge clk);
      a = ta; b = tb_v; is_signed = s; start = 1'b1;
      @(negedge clk);
      start = 1'b0; a = ~ta; b = ~tb_v; is_signed = ~s;
      edges = 1; busy_cyc = 0;
      while (!done && edges < 100) begin
         if (busy) busy_cyc++;
         @(negedge clk);
         edges++;
      end
   endtask

   task automatic op_check(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                           input logic s, input logic [63:0] exp);
      int e, bc;
      run_op(ta, tb_v, s, e, bc);
      chk({tag, "_lat"}, 64'(e), 64'd34);
      chk({tag, "_prod"}, {hi, lo}, exp);
   endtask

   // Watch n cycles, return 1 if done ever pulsed
   task automatic watch_done(input int n, output logic seen);
      seen = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
   endtask

   initial begin
      int e, bc, m;
      logic seen;
      logic [31:0] pool [6];
      logic [31:0] ra, rb;
      logic rs;
      longint sa, sb;
      logic [63:0] ref_p;

      rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; a = '0; b = '0; cancel = 1'b0;
      #22;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_hilo", {hi, lo}, 64'd0);
      @(negedge clk); rst_n = 1'b1;
      watch_done(3, seen);
      chk("release_no_start", 64'(busy), 64'd0);

      // Full-range MULTU with latency and busy-length checks
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, e, bc);
      chk("multu_ff_lat", 64'(e), 64'd34);
      chk("multu_ff_busy", 64'(bc), 64'd33);
      chk("multu_ff_busy_done_cyc", 64'(busy), 64'd0);
      chk("multu_ff_prod", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
      @(negedge clk);
      chk("done_one_cycle", 64'(done), 64'd0);

      op_check("mult_min_x_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_8000_0000);
      op_check("mult_m3_x_7",   32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB);
      op_check("mult_min_x_min",32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
      op_check("mult_min_x_2",  32'h8000_0000, 32'h0000_0002, 1'b1, 64'hFFFF_FFFF_0000_0000);
      op_check("multu_min_x_2", 32'h8000_0000, 32'h0000_0002, 1'b0, 64'h0000_0001_0000_0000);
      op_check("mult_m1_x_1",   32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
      op_check("multu_0_x_ff",  32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 64'h0);
      op_check("multu_shift",   32'h1234_5678, 32'h0000_0010, 1'b0, 64'h0000_0001_2345_6780);

      // start held high: mid-CALC operand change ignored, accepted again in done cycle
      @(negedge clk);
      a = 32'd5; b = 32'd6; is_signed = 1'b0; start = 1'b1;
      @(negedge clk);
      a = 32'd7; b = 32'd9; is_signed = 1'b1;
      e = 1;
      while (!done && e < 100) begin @(negedge clk); e++; end
      chk("hold_first_lat", 64'(e), 64'd34);
      chk("hold_first_prod", {hi, lo}, 64'd30);
      @(negedge clk);
      start = 1'b0;
      chk("b2b_accepted", 64'(busy), 64'd1);
      m = 1;
      while (!done && m < 100) begin @(negedge clk); m++; end
      chk("b2b_lat", 64'(m), 64'd34);
      chk("b2b_prod", {hi, lo}, 64'd63);

      // cancel on the 10th CALC edge (edge 11 counting the accepting edge)
      @(negedge clk);
      a = 32'd5; b = 32'd6; is_signed = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      cancel = 1'b1;
      @(negedge clk);
      cancel = 1'b0;
      chk("cancel_busy", 64'(busy), 64'd0);
      watch_done(40, seen);
      chk("cancel_no_done", 64'(seen), 64'd0);
      chk("cancel_hilo_kept", {hi, lo}, 64'd63);
      op_check("after_cancel", 32'd5, 32'd6, 1'b0, 64'd30);

      // cancel in IDLE blocks start
      @(negedge clk);
      a = 32'd3; b = 32'd3; start = 1'b1; cancel = 1'b1;
      @(negedge clk);
      start = 1'b0; cancel = 1'b0;
      chk("idle_cancel_blocks", 64'(busy), 64'd0);

      // async reset between edges mid-CALC
      @(negedge clk);
      a = 32'd11; b = 32'd13; is_signed = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_hilo", {hi, lo}, 64'd0);
      @(negedge clk); rst_n = 1'b1;
      watch_done(40, seen);
      chk("arst_no_done", 64'(seen), 64'd0);
      op_check("after_arst", 32'd11, 32'd13, 1'b0, 64'd143);

      // corner-biased random operands against a 64-bit reference product
      pool[0] = 32'h0; pool[1] = 32'h1; pool[2] = 32'hFFFF_FFFF;
      pool[3] = 32'h8000_0000; pool[4] = 32'h7FFF_FFFF; pool[5] = 32'h2;
      for (int i = 0; i < 120; i++) begin
         ra = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 5)] : $urandom;
         rb = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 5)] : $urandom;
         rs = 1'($urandom_range(0, 1));
         if (rs) begin
            sa = longint'($signed(ra)); sb = longint'($signed(rb));
            ref_p = 64'(sa * sb);
         end else begin
            ref_p = {32'h0, ra} * {32'h0, rb};
         end
         run_op(ra, rb, rs, e, bc);
         chk($sformatf("rand%0d_%h_%h_%0d", i, ra, rb, rs), {hi, lo}, ref_p);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mult_seq.md
MULT_SEQ -- requirements
Module: mult_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand width; legal values 4..64.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low; one clock, reset is asynchronous and active-low.
REQ-004 start  input  1  request a multiply; sampled only in IDLE.
REQ-005 is_signed  input  1  1 = MULT (two's complement), 0 = MULTU; sampled with start.
REQ-006 a  input  WIDTH  multiplicand; sampled with start.
REQ-007 b  input  WIDTH  multiplier; sampled with start.
REQ-008 cancel  input  1  pipeline flush; aborts an operation in progress.
REQ-009 busy  output  1  high while an operation is in progress (state != IDLE).
REQ-010 done  output  1  one-cycle pulse; hi/lo hold a new product.
REQ-011 hi  output  WIDTH  upper half of the 2*WIDTH-bit product.
REQ-012 lo  output  WIDTH  lower half of the 2*WIDTH-bit product.

Function
REQ-013 The FSM SHALL have states IDLE, CALC and FIX, encoded in registers.
REQ-014 IDLE: start=1 and cancel=0 at an edge SHALL latch the operands and is_signed, clear the accumulator, load a counter with WIDTH, and go to CALC.
REQ-015 Operand capture: for is_signed=1, each operand SHALL be stored as its magnitude, and the result sign SHALL be stored as a[WIDTH-1] XOR b[WIDTH-1]. For is_signed=0, operands SHALL be stored unchanged with result sign 0.
REQ-016 Magnitude of the most negative value (e.g. 0x80000000) SHALL be 2^(WIDTH-1), held as an unsigned WIDTH-bit value without overflow.
REQ-017 CALC: each edge performs one shift-add step.
  - If multiplier LSB = 1, add the multiplicand into the upper accumulator half, using a WIDTH+1-bit sum so the carry is kept.
  - Shift the {carry, accumulator, multiplier} register right by 1.
  - Decrement the counter.
REQ-018 When the counter reaches 0, CALC SHALL go to FIX.
REQ-019 FIX: one edge.
  - Write the 2*WIDTH-bit magnitude to {hi,lo}, two's-complement negated when the stored sign is 1.
  - Set done=1 and go to IDLE.
REQ-020 Latency: done SHALL be high only in the cycle after the (WIDTH+2)th rising edge counted from, and including, the accepting edge (34 edges for WIDTH=32).
REQ-021 done SHALL be low in every other cycle.
REQ-022 busy SHALL be high from the cycle after the accepting edge through the FIX cycle, and low in the done cycle.
REQ-023 hi and lo SHALL change only at the FIX edge or on reset, and SHALL otherwise hold the last product.
REQ-024 start while busy=1 SHALL be ignored, with no queuing.
REQ-025 start in the done cycle SHALL be accepted normally (back-to-back operation).
REQ-026 a, b and is_signed changing after acceptance SHALL NOT affect the result.
REQ-027 cancel=1 in CALC or FIX SHALL return to IDLE at that edge with no done pulse and hi/lo unchanged.
REQ-028 cancel=1 in IDLE SHALL block start at that edge; cancel has priority over start.
REQ-029 The product SHALL be exact, with no overflow flag: a 2*WIDTH-bit result always fits.

Reset
REQ-030 rst_n=0 SHALL immediately, without waiting for clk, force state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, and clear internal operand and accumulator registers.
REQ-031 Reset asserted mid-CALC SHALL abort with no done pulse; after release, the first start SHALL behave as from power-up.
REQ-032 Release of rst_n SHALL NOT by itself start an operation; a start is needed.

Verification
REQ-033 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done after 34 edges, hi=0xFFFFFFFE, lo=0x00000001, busy high for 33 cycles.
REQ-034 MULT a=0x80000000, b=0xFFFFFFFF (-2^31 * -1) -> hi=0x00000000, lo=0x80000000; MULT a=-3, b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-035 start held high through one operation with new a/b mid-CALC -> result uses the first operands; second operation accepted in the done cycle and completes 34 edges later.
REQ-036 cancel pulsed at the 10th CALC edge after MULTU 5*6 -> busy drops, no done, hi/lo keep the prior product; the next MULTU 5*6 gives lo=30, hi=0.
REQ-037 rst_n pulsed low asynchronously, between clock edges, mid-CALC -> outputs 0 before the next edge; no done follows.
REQ-038 Randomised: 10k MULT/MULTU pairs including 0, 1, -1 and the most negative value, compared against a 64-bit reference product, at WIDTH=32 and WIDTH=8.
